fpu: RTL and testbench
======================

FPU -- requirements
Module: fpu

Interface
REQ-001 SHALL declare no parameters; the format is fixed at IEEE-754 binary32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-005 SHALL have port op, input, 2 bits: 00 add, 01 sub (A-B), 10 mul, 11 reserved.
REQ-006 SHALL have port A, input, 32 bits: first operand, binary32.
REQ-007 SHALL have port B, input, 32 bits: second operand, binary32.
REQ-008 SHALL have port R, output, 32 bits: registered result, held until the next DONE state or reset.
REQ-009 SHALL have port done, output, 1 bit: registered one-cycle completion pulse.

Function
REQ-010 SHALL run FSM states IDLE, UNPACK, ALIGN, OPERATE, NORMALIZE, DONE, advancing one state per clock.
REQ-011 SHALL, in IDLE with start=1 at edge k, capture A, B and op and enter UNPACK.
REQ-012 SHALL reach DONE after edge k+4, with done=1 and R valid for exactly that cycle.
REQ-013 SHALL return to IDLE at edge k+5; if start is still high at edge k+6, start a new operation (6-cycle throughput).
REQ-014 SHALL ignore start and input changes while not in IDLE, because operands are latched at capture.
REQ-015 SHALL, for add/sub, apply the sign inversion of B for sub.
REQ-016 SHALL align the smaller-exponent significand by shifting right with hidden bit included; bits shifted out are truncated.
REQ-017 SHALL add or subtract the aligned significands using a 25-bit magnitude.
REQ-018 SHALL normalize the add/sub result via leading-zero count.
REQ-019 SHALL round toward zero (truncation) on all paths.
REQ-020 SHALL, for mul, XOR the signs, compute the exponent as eA+eB-127, and take the 24x24 significand product, normalized and truncated to 23 fraction bits.
REQ-021 SHALL produce +0 (0x00000000) when an exact-zero add/sub result occurs, including x-x.
REQ-022 SHALL flush subnormal inputs to zero of the same sign.
REQ-023 SHALL flush results with exponent <= 0 to signed zero.
REQ-024 SHALL produce signed infinity on exponent overflow (>= 255).
REQ-025 SHALL produce canonical NaN 0x7FC00000 for a NaN operand, Inf-Inf in effective subtraction, and Inf*0.
REQ-026 SHALL propagate Inf otherwise with the correct sign.
REQ-027 SHALL complete op=11 with the normal latency and R=0x00000000.

Reset
REQ-028 SHALL, with rst high at a clock edge, set state=IDLE, R=0x00000000, done=0.
REQ-029 SHALL give rst priority over start and over any in-flight operation.
REQ-030 SHALL abort an operation interrupted mid-flight with no done pulse.

Configuration
REQ-031 SHALL implement op=10 as multiply only when macro FPU_MUL_EN is defined.
REQ-032 SHALL, without FPU_MUL_EN, remove the multiplier and treat op=10 exactly as op=11: normal latency, R=0.

Structure
REQ-033 SHALL place in shared package fpu_pkg: op encodings, FSM state enum, EXP_BIAS=127, CANON_NAN=0x7FC00000, and field widths (sign 1, exp 8, frac 23).
REQ-034 SHALL implement the leading-zero count in one sub-module, fpu_lzc, used by NORMALIZE for add/sub and mul.

Verification
REQ-035 SHALL cover: A=0x3FA66666, B=0xBFB33333, op=00, start held high -> done after edge k+4 with R=0xBDCCCCD0, then repeating every 6 cycles.
REQ-036 SHALL cover: A=0x3F800000, B=0x3F800000, op=01 -> R=0x00000000.
REQ-037 SHALL cover: A=0x40000000, B=0x40400000, op=10 -> R=0x40C00000 with FPU_MUL_EN defined, and R=0x00000000 without it.
REQ-038 SHALL cover: A=0x7F800000, B=0xFF800000, op=00 -> R=0x7FC00000; also A=0x7F7FFFFF, B=0x7F7FFFFF, op=00 -> R=0x7F800000.
REQ-039 SHALL cover: rst pulsed in the OPERATE cycle -> no done pulse, R=0x00000000, FSM in IDLE, and a new start is accepted next cycle.
REQ-040 SHALL cover: A and B changed during busy cycles -> result still matches the captured operands.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the binary32 FPU: field widths, opcodes, FSM states.
package fpu_pkg;

    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_UNPACK    = 3'd1,
        S_ALIGN     = 3'd2,
        S_OPERATE   = 3'd3,
        S_NORMALIZE = 3'd4,
        S_DONE      = 3'd5
    } state_t;

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero count of a 48-bit significand; returns 48 for an all-zero input.
module fpu_lzc (
    input  logic [47:0] x,
    output logic [5:0]  cnt
);

    always_comb begin
        cnt = 6'd48;
        for (int i = 0; i < 48; i++) begin
            if (x[i]) cnt = 6'(47 - i);
        end
    end

endmodule

// File: rtl/fpu.sv
// Multi-cycle binary32 add/sub/mul, truncating, subnormals flushed to zero.
// Multiply is present only when FPU_MUL_EN is defined; otherwise op=10 returns +0.
//
//   state     | meaning
//   IDLE      | wait for start, capture A/B/op
//   UNPACK    | split fields, flush subnormals, resolve NaN/Inf/reserved
//   ALIGN     | order by magnitude and shift smaller significand (add/sub)
//   OPERATE   | add/sub magnitudes or multiply significands
//   NORMALIZE | leading-zero normalize, range check, build result
//   DONE      | done pulse, R valid
module fpu
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] R,
    output logic        done
);

    state_t state, state_nx;

    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        is_mul;

    logic              a_sign, b_sign;
    logic [EXP_W-1:0]  a_exp, b_exp;
    logic [FRAC_W-1:0] a_frac, b_frac;
    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic              spec_nx;
    logic [31:0]       spec_val_nx;

    logic              sa_u, sb_u, spec_q;
    logic [EXP_W-1:0]  ea_u, eb_u;
    logic [FRAC_W:0]   ma_u, mb_u;
    logic [31:0]       spec_val_q;

    logic               sign_al, effsub_al;
    logic signed [10:0] ebase_al;
    logic [FRAC_W:0]    mbig_al, msml_al;

    logic [24:0]        mag;
    logic [47:0]        prod;
    logic [47:0]        mant_op;

    logic [5:0]         lz;
    logic signed [10:0] exp_n;
    logic [FRAC_W-1:0]  frac_n;
    logic [31:0]        res_n;

`ifdef FPU_MUL_EN
    assign is_mul = (op_q == OP_MUL);
    assign prod   = {24'd0, mbig_al} * {24'd0, msml_al};
`else
    assign is_mul = 1'b0;
    assign prod   = 48'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (start) state_nx = S_UNPACK;
            S_UNPACK:    state_nx = S_ALIGN;
            S_ALIGN:     state_nx = S_OPERATE;
            S_OPERATE:   state_nx = S_NORMALIZE;
            S_NORMALIZE: state_nx = S_DONE;
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    assign a_sign = a_q[EXP_W+FRAC_W];
    assign b_sign = b_q[EXP_W+FRAC_W] ^ (op_q == OP_SUB);
    assign a_exp  = a_q[FRAC_W +: EXP_W];
    assign b_exp  = b_q[FRAC_W +: EXP_W];
    assign a_frac = a_q[FRAC_W-1:0];
    assign b_frac = b_q[FRAC_W-1:0];
    assign nan_a  = (&a_exp) && (|a_frac);
    assign nan_b  = (&b_exp) && (|b_frac);
    assign inf_a  = (&a_exp) && !(|a_frac);
    assign inf_b  = (&b_exp) && !(|b_frac);
    assign zero_a = (a_exp == '0);
    assign zero_b = (b_exp == '0);

    // Special operands settle the result here; the datapath result is then ignored.
    always_comb begin
        spec_nx     = 1'b0;
        spec_val_nx = '0;
        if (op_q == OP_ADD || op_q == OP_SUB) begin
            if (nan_a || nan_b || (inf_a && inf_b && (a_sign != b_sign))) begin
                spec_nx     = 1'b1;
                spec_val_nx = CANON_NAN;
            end else if (inf_a) begin
                spec_nx     = 1'b1;
                spec_val_nx = {a_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            end else if (inf_b) begin
                spec_nx     = 1'b1;
                spec_val_nx = {b_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            end
        end else if (is_mul) begin
            if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
                spec_nx     = 1'b1;
                spec_val_nx = CANON_NAN;
            end else if (inf_a || inf_b) begin
                spec_nx     = 1'b1;
                spec_val_nx = {a_sign ^ b_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            end else if (zero_a || zero_b) begin
                spec_nx     = 1'b1;
                spec_val_nx = {a_sign ^ b_sign, {(EXP_W+FRAC_W){1'b0}}};
            end
        end else begin
            spec_nx     = 1'b1;
            spec_val_nx = '0;
        end
    end

    assign mag = effsub_al ? ({1'b0, mbig_al} - {1'b0, msml_al})
                           : ({1'b0, mbig_al} + {1'b0, msml_al});

    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: if (start) begin
                op_q <= op;
                a_q  <= A;
                b_q  <= B;
            end
            S_UNPACK: begin
                sa_u       <= a_sign;
                sb_u       <= b_sign;
                ea_u       <= a_exp;
                eb_u       <= b_exp;
                ma_u       <= zero_a ? '0 : {1'b1, a_frac};
                mb_u       <= zero_b ? '0 : {1'b1, b_frac};
                spec_q     <= spec_nx;
                spec_val_q <= spec_val_nx;
            end
            S_ALIGN: begin
                if (is_mul) begin
                    sign_al   <= sa_u ^ sb_u;
                    effsub_al <= 1'b0;
                    ebase_al  <= $signed({3'd0, ea_u}) + $signed({3'd0, eb_u}) - 11'(EXP_BIAS);
                    mbig_al   <= ma_u;
                    msml_al   <= mb_u;
                end else if ({ea_u, ma_u} >= {eb_u, mb_u}) begin
                    sign_al   <= sa_u;
                    effsub_al <= sa_u ^ sb_u;
                    ebase_al  <= $signed({3'd0, ea_u});
                    mbig_al   <= ma_u;
                    msml_al   <= mb_u >> (ea_u - eb_u);
                end else begin
                    sign_al   <= sb_u;
                    effsub_al <= sa_u ^ sb_u;
                    ebase_al  <= $signed({3'd0, eb_u});
                    mbig_al   <= mb_u;
                    msml_al   <= ma_u >> (eb_u - ea_u);
                end
            end
            // Both paths place the 2^1 weight at bit 47 so one normalizer serves them.
            S_OPERATE: mant_op <= is_mul ? prod : {mag, 23'd0};
            default: ;
        endcase
    end

    fpu_lzc u_lzc (
        .x   (mant_op),
        .cnt (lz)
    );

    assign exp_n  = ebase_al + 11'sd1 - $signed({5'd0, lz});
    assign frac_n = FRAC_W'((mant_op << lz) >> 24);

    always_comb begin
        res_n = {sign_al, exp_n[EXP_W-1:0], frac_n};
        if (spec_q)
            res_n = spec_val_q;
        else if (mant_op == '0)
            res_n = '0;
        else if (exp_n >= 11'sd255)
            res_n = {sign_al, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else if (exp_n <= 11'sd0)
            res_n = {sign_al, {(EXP_W+FRAC_W){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            R    <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == S_NORMALIZE);
            if (state == S_NORMALIZE) R <= res_n;
        end
    end

endmodule

// File: tb/tb_fpu.sv
// Directed bench for fpu: latency, throughput, arithmetic vectors, specials, mid-flight reset.
module tb_fpu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A, B;
    logic [31:0] R;
    logic        done;

    int n_chk = 0;
    int n_err = 0;

`ifdef FPU_MUL_EN
    localparam logic [31:0] EXP_MUL_2X3   = 32'h40C0_0000;
    localparam logic [31:0] EXP_MUL_INF_0 = 32'h7FC0_0000;
    localparam logic [31:0] EXP_MUL_15X15 = 32'h4010_0000;
`else
    localparam logic [31:0] EXP_MUL_2X3   = 32'h0000_0000;
    localparam logic [31:0] EXP_MUL_INF_0 = 32'h0000_0000;
    localparam logic [31:0] EXP_MUL_15X15 = 32'h0000_0000;
`endif

    fpu dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .R     (R),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Operands are scrambled right after capture; the result must follow the captured values.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] o, input logic [31:0] exp);
        int lat;
        A = a; B = b; op = o; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3));
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        chk({tag, "_r"}, R, exp);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_hold"}, R, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_r", R, 32'h0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // start held high: done at k+4 and k+10
        A = 32'h3FA6_6666; B = 32'hBFB3_3333; op = 2'b00; start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk($sformatf("held_done_%0d", i), {31'd0, done}, {31'd0, (i == 4 || i == 10)});
            if (i == 4 || i == 10) chk($sformatf("held_r_%0d", i), R, 32'hBDCC_CCD0);
        end
        start = 1'b0;

        run_op("sub_x_x",   32'h3F80_0000, 32'h3F80_0000, 2'b01, 32'h0000_0000);
        run_op("mul_2x3",   32'h4000_0000, 32'h4040_0000, 2'b10, EXP_MUL_2X3);
        run_op("mul_15sq",  32'h3FC0_0000, 32'h3FC0_0000, 2'b10, EXP_MUL_15X15);
        run_op("mul_inf0",  32'h7F80_0000, 32'h0000_0000, 2'b10, EXP_MUL_INF_0);
        run_op("inf_ninf",  32'h7F80_0000, 32'hFF80_0000, 2'b00, 32'h7FC0_0000);
        run_op("ovf",       32'h7F7F_FFFF, 32'h7F7F_FFFF, 2'b00, 32'h7F80_0000);
        run_op("nan_in",    32'h7FC0_0001, 32'h3F80_0000, 2'b00, 32'h7FC0_0000);
        run_op("inf_m1",    32'h7F80_0000, 32'h3F80_0000, 2'b01, 32'h7F80_0000);
        run_op("subn_ftz",  32'h0000_0001, 32'h3F80_0000, 2'b00, 32'h3F80_0000);
        run_op("one_mhalf", 32'h3F80_0000, 32'h3F00_0000, 2'b01, 32'h3F00_0000);
        run_op("neg_sum",   32'hBF80_0000, 32'h3F00_0000, 2'b00, 32'hBF00_0000);
        run_op("unf",       32'h00C0_0000, 32'h0080_0000, 2'b01, 32'h0000_0000);
        run_op("rsv",       32'h3F80_0000, 32'h3F80_0000, 2'b11, 32'h0000_0000);
        run_op("one_p1",    32'h3F80_0000, 32'h3F80_0000, 2'b00, 32'h4000_0000);

        // reset during OPERATE aborts without a done pulse
        A = 32'h4000_0000; B = 32'h4000_0000; op = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_r", R, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort_quiet_%0d", i), {31'd0, done}, 32'd0);
            if (i < 2) begin
                @(negedge clk);
            end
        end
        @(posedge clk); #1;
        run_op("after_rst", 32'h4000_0000, 32'h3F80_0000, 2'b00, 32'h4040_0000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
